accu_sequencer: RTL and testbench

Sequences the convolution-layer accumulation datapath: the bias/partial-sum adder that sits behind each convolution unit and the partial-sum buffer it feeds. Over one filter group it walks every output pixel once per input channel. On channel 0 it selects the bias as the adder's second operand; on later channels it selects the stored partial sum. On the last channel it flags each adder result as final. It then advances the filter group (the bias index) until all groups are done and reports completion to the layer controller.

---
 rtl/accu_sequencer.sv | 118 +++++++++++
 tb/tb_accu_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/accu_sequencer.sv
// accu_sequencer: control for the convolution-layer bias/partial-sum adder and
// the partial-sum buffer. It walks every output pixel once per input channel.
// For each filter group it selects bias on channel 0 and the stored partial
// sum on later channels. Results on the last channel are flagged as final.
module accu_sequencer #(
   parameter int IFM_SIZE_NEXT           = 10,
   parameter int IFM_DEPTH               = 3,
   parameter int NUMBER_OF_FILTERS       = 16,
   parameter int NUMBER_OF_UNITS         = 3,
   parameter int NUMBER_OF_GROUPS        = NUMBER_OF_FILTERS / NUMBER_OF_UNITS + 1,
   parameter int ADDRESS_SIZE_NEXT_IFM   = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
   parameter int NUMBER_OF_BITS_CHANNELS = $clog2(IFM_DEPTH) + 1,
   parameter int GROUP_BITS              = $clog2(NUMBER_OF_GROUPS) + 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             conv_valid,
   output logic                             accu_enable,
   output logic [ADDRESS_SIZE_NEXT_IFM-1:0] psum_addr,
   output logic                             psum_we,
   output logic [GROUP_BITS-1:0]            bias_sel,
   output logic                             out_valid,
   output logic [ADDRESS_SIZE_NEXT_IFM-1:0] out_addr,
   output logic                             busy,
   output logic                             done
);

   localparam int unsigned PIXELS = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
   localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0]   PIX_LAST = ADDRESS_SIZE_NEXT_IFM'(PIXELS - 1);
   localparam logic [NUMBER_OF_BITS_CHANNELS-1:0] CH_LAST  = NUMBER_OF_BITS_CHANNELS'(IFM_DEPTH - 1);
   localparam logic [GROUP_BITS-1:0]              GRP_LAST = GROUP_BITS'(NUMBER_OF_GROUPS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      NEXT_GROUP,
      DONE
   } state_t;

   state_t                             state, state_nx;
   logic [ADDRESS_SIZE_NEXT_IFM-1:0]   pix, pix_nx;
   logic [NUMBER_OF_BITS_CHANNELS-1:0] ch, ch_nx;
   logic [GROUP_BITS-1:0]              grp, grp_nx;

   // State and counter registers; reset aborts a pass immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         pix   <= '0;
         ch    <= '0;
         grp   <= '0;
      end else begin
         state <= state_nx;
         pix   <= pix_nx;
         ch    <= ch_nx;
         grp   <= grp_nx;
      end
   end

   // Next state and counter advance. Counters move only on accepted beats.
   always_comb begin
      state_nx = state;
      pix_nx   = pix;
      ch_nx    = ch;
      grp_nx   = grp;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = ACCUM;
               pix_nx   = '0;
               ch_nx    = '0;
               grp_nx   = '0;
            end
         end
         ACCUM: begin
            if (conv_valid) begin
               if (pix == PIX_LAST) begin
                  pix_nx = '0;
                  if (ch == CH_LAST) begin
                     ch_nx    = '0;
                     state_nx = (grp == GRP_LAST) ? DONE : NEXT_GROUP;
                  end else begin
                     ch_nx = ch + 1'b1;
                  end
               end else begin
                  pix_nx = pix + 1'b1;
               end
            end
         end
         NEXT_GROUP: begin
            grp_nx   = grp + 1'b1;
            pix_nx   = '0;
            ch_nx    = '0;
            state_nx = ACCUM;
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Datapath controls, decoded from the registered state and counters.
   always_comb begin
      accu_enable = (ch != '0);
      psum_addr   = pix;
      out_addr    = pix;
      bias_sel    = grp;
      psum_we     = (state == ACCUM) && conv_valid;
      out_valid   = (state == ACCUM) && conv_valid && (ch == CH_LAST);
      busy        = (state != IDLE);
      done        = (state == DONE);
   end

endmodule

// File: tb/tb_accu_sequencer.sv
// Directed bench for accu_sequencer with default parameters
// (10x10 output map, 3 channels, 6 filter groups).
module tb_accu_sequencer;

   localparam int P = 100;
   localparam int D = 3;
   localparam int G = 6;

   logic       clk;
   logic       reset;
   logic       start;
   logic       conv_valid;
   logic       accu_enable;
   logic [6:0] psum_addr;
   logic       psum_we;
   logic [3:0] bias_sel;
   logic       out_valid;
   logic [6:0] out_addr;
   logic       busy;
   logic       done;

   int tests;
   int fails;

   accu_sequencer #(
      .IFM_SIZE_NEXT     (10),
      .IFM_DEPTH         (3),
      .NUMBER_OF_FILTERS (16),
      .NUMBER_OF_UNITS   (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .conv_valid  (conv_valid),
      .accu_enable (accu_enable),
      .psum_addr   (psum_addr),
      .psum_we     (psum_we),
      .bias_sel    (bias_sel),
      .out_valid   (out_valid),
      .out_addr    (out_addr),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic       cv;
      logic       accu;
      logic [6:0] addr;
      logic       we;
      logic [3:0] bsel;
      logic       ov;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t vecs [12];

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic expect_out(input string nm, input logic e_accu, input logic [6:0] e_addr,
                             input logic e_we, input logic [3:0] e_bsel, input logic e_ov,
                             input logic e_busy, input logic e_done);
      cmp({nm, ".accu_enable"}, 32'(accu_enable), 32'(e_accu));
      cmp({nm, ".psum_addr"},   32'(psum_addr),   32'(e_addr));
      cmp({nm, ".out_addr"},    32'(out_addr),    32'(e_addr));
      cmp({nm, ".psum_we"},     32'(psum_we),     32'(e_we));
      cmp({nm, ".bias_sel"},    32'(bias_sel),    32'(e_bsel));
      cmp({nm, ".out_valid"},   32'(out_valid),   32'(e_ov));
      cmp({nm, ".busy"},        32'(busy),        32'(e_busy));
      cmp({nm, ".done"},        32'(done),        32'(e_done));
   endtask

   // Apply inputs just after the falling edge, then let outputs settle.
   task automatic drive(input logic s, input logic cv);
      @(negedge clk);
      start      = s;
      conv_valid = cv;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset      = 1'b0;
      start      = 1'b0;
      conv_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Continuous beats of group g starting from pix=0, ch=0.
   task automatic walk(input int g, input int nbeats);
      for (int b = 0; b < nbeats; b++) begin
         int c;
         int p;
         c = b / P;
         p = b % P;
         drive(1'b0, 1'b1);
         expect_out($sformatf("g%0d_b%0d", g, b), (c != 0), 7'(p), 1'b1, 4'(g),
                    (c == D - 1), 1'b1, 1'b0);
      end
   endtask

   // Inter-group bubble: conv_valid is offered but must not be accepted.
   task automatic next_group_chk(input int g);
      drive(1'b0, 1'b1);
      expect_out($sformatf("ng%0d", g), 1'b0, 7'd0, 1'b0, 4'(g), 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      int we_cnt;
      int ov_cnt;
      int done_cnt;
      int max_bsel;
      int cyc;
      bit seen_done;

      tests      = 0;
      fails      = 0;
      reset      = 1'b0;
      start      = 1'b0;
      conv_valid = 1'b0;

      // start, cv, accu, addr, we, bsel, ov, busy, done
      for (int i = 0; i < 5; i++)
         vecs[i] = '{1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 7'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 7'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 7'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 7'd1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 7'd2, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 7'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0};

      // Reset state, idle with conv_valid, start, stalls, start while busy.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].start, vecs[i].cv);
         expect_out($sformatf("vec%0d", i), vecs[i].accu, vecs[i].addr, vecs[i].we,
                    vecs[i].bsel, vecs[i].ov, vecs[i].busy, vecs[i].done);
      end

      // Group 0 in full, the NEXT_GROUP bubble, then the first beat of group 1.
      do_reset();
      drive(1'b1, 1'b0);
      walk(0, P * D);
      next_group_chk(0);
      drive(1'b0, 1'b1);
      expect_out("g1_first", 1'b0, 7'd0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);

      // Start pulsed at beat 50 of group 0 has no effect.
      do_reset();
      drive(1'b1, 1'b0);
      walk(0, 50);
      drive(1'b1, 1'b1);
      expect_out("start_busy_b50", 1'b0, 7'd50, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1);
      expect_out("start_busy_b51", 1'b0, 7'd51, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);

      // Full pass with conv_valid toggling every cycle.
      do_reset();
      drive(1'b1, 1'b0);
      we_cnt    = 0;
      ov_cnt    = 0;
      done_cnt  = 0;
      max_bsel  = 0;
      seen_done = 0;
      cyc       = 0;
      while (!seen_done && cyc < 5000) begin
         drive(1'b0, (cyc % 2) == 0);
         if (psum_we === 1'b1) we_cnt++;
         if (out_valid === 1'b1) ov_cnt++;
         if (int'(bias_sel) > max_bsel) max_bsel = int'(bias_sel);
         if (done === 1'b1) begin
            done_cnt++;
            seen_done = 1;
            cmp("done_cycle.busy", 32'(busy), 32'd1);
            cmp("done_cycle.bias_sel", 32'(bias_sel), 32'(G - 1));
            cmp("done_cycle.psum_we", 32'(psum_we), 32'd0);
         end
         cyc++;
      end
      cmp("pass_timeout", 32'(seen_done), 32'd1);
      cmp("pass.psum_we_beats", 32'(we_cnt), 32'(G * P * D));
      cmp("pass.out_valid_beats", 32'(ov_cnt), 32'(G * P));
      cmp("pass.max_bias_sel", 32'(max_bsel), 32'(G - 1));
      cmp("pass.done_pulses", 32'(done_cnt), 32'd1);
      drive(1'b0, 1'b1);
      cmp("after_done.busy", 32'(busy), 32'd0);
      cmp("after_done.done", 32'(done), 32'd0);
      cmp("after_done.psum_we", 32'(psum_we), 32'd0);

      // Reset at beat 150 of group 2 aborts; a later start begins afresh.
      do_reset();
      drive(1'b1, 1'b0);
      walk(0, P * D);
      next_group_chk(0);
      walk(1, P * D);
      next_group_chk(1);
      walk(2, 150);
      @(negedge clk);
      reset      = 1'b0;
      conv_valid = 1'b1;
      #1;
      expect_out("abort_async", 1'b0, 7'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      expect_out("abort_next", 1'b0, 7'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      drive(1'b1, 1'b0);
      expect_out("restart_idle", 1'b0, 7'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1);
      expect_out("restart_first", 1'b0, 7'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1);
      expect_out("restart_second", 1'b0, 7'd1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
